block_read_accumulator: RTL and testbench

// Downstream consumer of the multiplier's block-read port. On a start request it raises
// EN_blockRead and collects the burst of VALID_memVal/memVal_data product words. It

---
 rtl/block_read_accumulator.sv | 145 ++++++++++++++
 tb/tb_block_read_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_read_accumulator.sv
// Block-read consumer: requests a burst from the multiplier, reduces it to
// sum / max / beat count, and holds the result on a valid/ready port.
module block_read_accumulator #(
  parameter int LOGDEPTH  = 6,
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = WIDTH + LOGDEPTH,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 EN_blockRead,
  input  logic                 VALID_memVal,
  input  logic [WIDTH-1:0]     memVal_data,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ACC_WIDTH-1:0] result_sum,
  output logic [WIDTH-1:0]     result_max,
  output logic [LOGDEPTH:0]    result_count,
  output logic                 result_timeout
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT);
  localparam logic [LOGDEPTH:0] FULL = (LOGDEPTH + 1)'(2 ** LOGDEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ACC_WIDTH-1:0] sum_q, sum_d, acc_sum;
  logic [WIDTH-1:0]     max_q, max_d, acc_max;
  logic [LOGDEPTH:0]    cnt_q, cnt_d, acc_cnt;
  logic [TW-1:0]        tmr_q, tmr_d;

  logic [ACC_WIDTH-1:0] res_sum_q;
  logic [WIDTH-1:0]     res_max_q;
  logic [LOGDEPTH:0]    res_cnt_q;
  logic                 res_to_q;
  logic                 load_res, res_to;

  assign acc_sum = sum_q + ACC_WIDTH'(memVal_data);
  assign acc_max = (memVal_data > max_q) ? memVal_data : max_q;
  assign acc_cnt = cnt_q + (LOGDEPTH + 1)'(1);

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    max_d    = max_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    load_res = 1'b0;
    res_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          sum_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      S_REQ: begin
        tmr_d = tmr_q + TW'(1);
        if (VALID_memVal) begin
          // First beat is taken in REQ so the burst loses no cycle.
          sum_d    = acc_sum;
          max_d    = acc_max;
          cnt_d    = acc_cnt;
          load_res = (acc_cnt == FULL);
          state_d  = (acc_cnt == FULL) ? S_DONE : S_COLLECT;
        end else if (tmr_q == TMAX) begin
          state_d  = S_DONE;
          load_res = 1'b1;
          res_to   = 1'b1;
        end
      end
      S_COLLECT: begin
        if (VALID_memVal) begin
          sum_d = acc_sum;
          max_d = acc_max;
          cnt_d = acc_cnt;
          if (acc_cnt == FULL) begin
            state_d  = S_DONE;
            load_res = 1'b1;
          end
        end else begin
          state_d  = S_DONE;
          load_res = 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  // Result copy is separate so it survives the accumulator clear on the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_sum_q <= '0;
      res_max_q <= '0;
      res_cnt_q <= '0;
      res_to_q  <= 1'b0;
    end else if (load_res) begin
      res_sum_q <= sum_d;
      res_max_q <= max_d;
      res_cnt_q <= cnt_d;
      res_to_q  <= res_to;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign EN_blockRead   = (state_q == S_REQ);
  assign result_valid   = (state_q == S_DONE);
  assign result_sum     = res_sum_q;
  assign result_max     = res_max_q;
  assign result_count   = res_cnt_q;
  assign result_timeout = res_to_q;

endmodule

// File: tb/tb_block_read_accumulator.sv
// Directed bench for block_read_accumulator with hand-computed expectations.
module tb_block_read_accumulator;

  localparam int LOGDEPTH  = 6;
  localparam int WIDTH     = 32;
  localparam int ACC_WIDTH = WIDTH + LOGDEPTH;
  localparam int TIMEOUT   = 255;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 busy;
  logic                 EN_blockRead;
  logic                 VALID_memVal;
  logic [WIDTH-1:0]     memVal_data;
  logic                 result_valid;
  logic                 result_ready;
  logic [ACC_WIDTH-1:0] result_sum;
  logic [WIDTH-1:0]     result_max;
  logic [LOGDEPTH:0]    result_count;
  logic                 result_timeout;

  int checks = 0;
  int errors = 0;

  block_read_accumulator #(
    .LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_sum(result_sum), .result_max(result_max),
    .result_count(result_count), .result_timeout(result_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Bounded wait for result_valid; returns number of negedges waited.
  task automatic wait_done(input int limit, output int waited);
    waited = 0;
    while (result_valid !== 1'b1 && waited < limit) begin
      tick();
      waited++;
    end
    check("wait_done_in_bound", 64'(result_valid), 64'd1);
  endtask

  int en_cnt;
  int waited;
  logic [ACC_WIDTH-1:0] held_sum;

  initial begin
    rst = 1'b0; start = 1'b0; VALID_memVal = 1'b0; memVal_data = '0; result_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_en",     64'(EN_blockRead), 64'd0);
    check("rst_rvalid", 64'(result_valid), 64'd0);
    check("rst_sum",    64'(result_sum), 64'd0);
    check("rst_count",  64'(result_count), 64'd0);
    rst = 1'b1;
    tick();

    // Full burst: data = i*3, first beat in the second REQ cycle.
    result_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    en_cnt = 0;
    en_cnt += int'(EN_blockRead);
    tick();
    en_cnt += int'(EN_blockRead);
    VALID_memVal = 1'b1; memVal_data = 32'd0;
    for (int i = 1; i < 64; i++) begin
      tick();
      en_cnt += int'(EN_blockRead);
      memVal_data = 32'(i * 3);
    end
    tick();
    en_cnt += int'(EN_blockRead);
    VALID_memVal = 1'b0;
    check("full_rvalid_latency", 64'(result_valid), 64'd1);
    check("full_sum",     64'(result_sum), 64'd6048);
    check("full_max",     64'(result_max), 64'd189);
    check("full_count",   64'(result_count), 64'd64);
    check("full_timeout", 64'(result_timeout), 64'd0);
    check("full_en_cycles", 64'(en_cnt), 64'd2);
    result_ready = 1'b1;
    tick();
    check("full_idle_after_accept", 64'(busy), 64'd0);
    check("full_hold_after_accept", 64'(result_sum), 64'd6048);

    // Reset mid-REQ: EN_blockRead must drop without a clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("req_en_before_rst", 64'(EN_blockRead), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_req_en", 64'(EN_blockRead), 64'd0);
    check("rst_req_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-COLLECT.
    start = 1'b1;
    tick();
    start = 1'b0;
    VALID_memVal = 1'b1; memVal_data = 32'd4;
    tick();
    tick();
    check("collect_busy_before_rst", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_col_en",     64'(EN_blockRead), 64'd0);
    check("rst_col_busy",   64'(busy), 64'd0);
    check("rst_col_rvalid", 64'(result_valid), 64'd0);
    check("rst_col_sum",    64'(result_sum), 64'd0);
    VALID_memVal = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_col_idle", 64'(busy), 64'd0);

    // Short burst {7,0,FFFFFFFF,2,9} then a gap; DONE 6 cycles after first beat.
    result_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    VALID_memVal = 1'b1; memVal_data = 32'd7;
    tick(); memVal_data = 32'd0;
    tick(); memVal_data = 32'hFFFF_FFFF;
    tick(); memVal_data = 32'd2;
    tick(); memVal_data = 32'd9;
    tick(); VALID_memVal = 1'b0;
    check("short_not_done_on_gap", 64'(result_valid), 64'd0);
    tick();
    check("short_rvalid", 64'(result_valid), 64'd1);
    check("short_sum",    64'(result_sum), 64'h1_0000_0011);
    check("short_max",    64'(result_max), 64'hFFFF_FFFF);
    check("short_count",  64'(result_count), 64'd5);
    result_ready = 1'b1;
    tick();

    // Timeout: no beat ever arrives.
    result_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1000, waited);
    check("to_latency", 64'(waited), 64'(TIMEOUT + 1));
    check("to_flag",  64'(result_timeout), 64'd1);
    check("to_count", 64'(result_count), 64'd0);
    check("to_sum",   64'(result_sum), 64'd0);
    check("to_max",   64'(result_max), 64'd0);
    result_ready = 1'b1;
    tick();

    // Backpressure: {5,3} then hold DONE while poking start/valid.
    result_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    VALID_memVal = 1'b1; memVal_data = 32'd5;
    tick(); memVal_data = 32'd3;
    tick(); VALID_memVal = 1'b0;
    tick();
    check("bp_rvalid", 64'(result_valid), 64'd1);
    check("bp_to_clear", 64'(result_timeout), 64'd0);
    held_sum = result_sum;
    check("bp_sum", 64'(held_sum), 64'd8);
    for (int i = 0; i < 10; i++) begin
      start = (i == 2 || i == 6);
      VALID_memVal = (i >= 3 && i <= 5);
      memVal_data = 32'hDEAD_0000 + 32'(i);
      tick();
      check("bp_hold_rvalid", 64'(result_valid), 64'd1);
      check("bp_hold_sum",    64'(result_sum), 64'd8);
      check("bp_hold_max",    64'(result_max), 64'd5);
      check("bp_hold_en",     64'(EN_blockRead), 64'd0);
    end
    start = 1'b0; VALID_memVal = 1'b0;
    result_ready = 1'b1;
    tick();
    check("bp_idle",   64'(busy), 64'd0);
    check("bp_rvalid_low", 64'(result_valid), 64'd0);
    check("bp_keep_count", 64'(result_count), 64'd2);
    tick();
    check("bp_no_restart", 64'(busy), 64'd0);

    // Overlong burst: 70 ones, only 64 counted.
    result_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    VALID_memVal = 1'b1; memVal_data = 32'd1;
    repeat (70) tick();
    VALID_memVal = 1'b0;
    wait_done(10, waited);
    check("ovl_count", 64'(result_count), 64'd64);
    check("ovl_sum",   64'(result_sum), 64'd64);
    check("ovl_max",   64'(result_max), 64'd1);
    result_ready = 1'b1;
    tick();
    check("ovl_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
